// File: rtl/majority_vote_sequencer.sv
// Five-voter majority decision sequencer: opens a window on start, collects one vote per
// voter through valid/ready, and closes on early majority, a full vote set, or timeout.
module majority_vote_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter bit          EARLY_DECIDE   = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [4:0] i_vote_valid,
  input  logic [4:0] i_vote_val,
  output logic [4:0] o_vote_ready,
  output logic       o_busy,
  output logic       o_decided,
  output logic       o_result,
  output logic       o_early,
  output logic       o_timed_out,
  output logic [4:0] o_voted_mask,
  output logic [2:0] o_yes_count,
  output logic [2:0] o_no_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DONE
  } state_t;

  function automatic logic [2:0] popCount5(input logic [4:0] v);
    logic [2:0] c;
    c = 3'd0;
    for (int i = 0; i < 5; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  state_t        r_state;
  logic [4:0]    r_votedMask;
  logic [4:0]    r_voteReady;
  logic [2:0]    r_yesCount;
  logic [2:0]    r_noCount;
  logic [TW-1:0] r_timer;
  logic          r_busy;
  logic          r_decided;
  logic          r_result;
  logic          r_early;
  logic          r_timedOut;

  state_t        w_stateNext;
  logic [4:0]    w_votedMaskNext;
  logic [4:0]    w_voteReadyNext;
  logic [2:0]    w_yesCountNext;
  logic [2:0]    w_noCountNext;
  logic [TW-1:0] w_timerNext;
  logic          w_busyNext;
  logic          w_decidedNext;
  logic          w_resultNext;
  logic          w_earlyNext;
  logic          w_timedOutNext;

  // Ready is only non-zero in COLLECT, so this already excludes duplicate and idle votes.
  logic [4:0]    w_accept;
  logic [4:0]    w_maskPost;
  logic [2:0]    w_yesPost;
  logic [2:0]    w_noPost;
  logic [TW-1:0] w_timerPost;
  logic          w_allVoted;
  logic          w_majority;
  logic          w_timerExpire;

  assign w_accept      = i_vote_valid & r_voteReady;
  assign w_maskPost    = r_votedMask | w_accept;
  assign w_yesPost     = r_yesCount + popCount5(w_accept & i_vote_val);
  assign w_noPost      = r_noCount + popCount5(w_accept & ~i_vote_val);
  assign w_timerPost   = r_timer + TW'(1);
  assign w_allVoted    = &w_maskPost;
  assign w_majority    = EARLY_DECIDE && ((w_yesPost >= 3'd3) || (w_noPost >= 3'd3));
  assign w_timerExpire = (w_timerPost == TW'(TIMEOUT_CYCLES));

  always_comb begin
    w_stateNext     = r_state;
    w_votedMaskNext = r_votedMask;
    w_yesCountNext  = r_yesCount;
    w_noCountNext   = r_noCount;
    w_timerNext     = r_timer;
    w_resultNext    = r_result;
    w_earlyNext     = r_early;
    w_timedOutNext  = r_timedOut;
    w_voteReadyNext = 5'b00000;
    w_busyNext      = 1'b0;
    w_decidedNext   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_stateNext     = S_COLLECT;
          w_votedMaskNext = 5'b00000;
          w_yesCountNext  = 3'd0;
          w_noCountNext   = 3'd0;
          w_timerNext     = '0;
          w_resultNext    = 1'b0;
          w_earlyNext     = 1'b0;
          w_timedOutNext  = 1'b0;
          w_busyNext      = 1'b1;
          w_voteReadyNext = 5'b11111;
        end
      end
      S_COLLECT: begin
        w_votedMaskNext = w_maskPost;
        w_yesCountNext  = w_yesPost;
        w_noCountNext   = w_noPost;
        w_timerNext     = w_timerPost;
        // A full vote set outranks early majority, which outranks timeout.
        if (w_allVoted || w_majority || w_timerExpire) begin
          w_stateNext    = S_DONE;
          w_decidedNext  = 1'b1;
          w_resultNext   = (w_yesPost >= 3'd3);
          w_earlyNext    = !w_allVoted && w_majority;
          w_timedOutNext = !w_allVoted && !w_majority && w_timerExpire;
        end else begin
          w_busyNext      = 1'b1;
          w_voteReadyNext = ~w_maskPost;
        end
      end
      S_DONE: begin
        w_stateNext = S_IDLE;
      end
      default: begin
        w_stateNext = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_votedMask <= 5'b00000;
      r_voteReady <= 5'b00000;
      r_yesCount  <= 3'd0;
      r_noCount   <= 3'd0;
      r_timer     <= '0;
      r_busy      <= 1'b0;
      r_decided   <= 1'b0;
      r_result    <= 1'b0;
      r_early     <= 1'b0;
      r_timedOut  <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_votedMask <= w_votedMaskNext;
      r_voteReady <= w_voteReadyNext;
      r_yesCount  <= w_yesCountNext;
      r_noCount   <= w_noCountNext;
      r_timer     <= w_timerNext;
      r_busy      <= w_busyNext;
      r_decided   <= w_decidedNext;
      r_result    <= w_resultNext;
      r_early     <= w_earlyNext;
      r_timedOut  <= w_timedOutNext;
    end
  end

  assign o_vote_ready = r_voteReady;
  assign o_busy       = r_busy;
  assign o_decided    = r_decided;
  assign o_result     = r_result;
  assign o_early      = r_early;
  assign o_timed_out  = r_timedOut;
  assign o_voted_mask = r_votedMask;
  assign o_yes_count  = r_yesCount;
  assign o_no_count   = r_noCount;

endmodule
